// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and default sizing for the unified-memory arbiter.
//   state_e : sequencer states (IDLE -> ACCESS -> RESP)
//   grant_e : which requester owns the current access
// Optional build macro used by the importing modules: MEM_ARB_RR_EN
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
// Combinational winner selection between the fetch and data requesters.
// Build macro: MEM_ARB_RR_EN selects round-robin on simultaneous requests;
// without it, data always wins over fetch.
// Ports:
//   if_req, d_req  in  : pending requests
//   last_grant     in  : owner of the previous access (round-robin only)
//   grant          out : selected requester
//   valid          out : at least one request pending
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output grant_e grant,
  output logic   valid
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority never looks at history; keep the port for a uniform interface.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Winner selection: a lone requester always wins; a tie is resolved by build mode.
  always_comb begin
    valid = if_req | d_req;
    grant = GNT_DATA;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) begin
      grant = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (d_req) begin
      grant = GNT_DATA;
    end else begin
      grant = GNT_FETCH;
    end
`else
    if (d_req) begin
      grant = GNT_DATA;
    end else begin
      grant = GNT_FETCH;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single 512x32 memory port between instruction fetch and
// load/store. Each access runs IDLE -> ACCESS -> RESP; every output is a
// register, so the memory's combinational read path ends in a flop.
// Out-of-range addresses never strobe the memory and answer with err.
// Build macro: MEM_ARB_RR_EN (round-robin arbitration on ties).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr/if_ack/if_rdata  : fetch requester
//   d_req/d_we/d_addr/d_wdata       : data requester inputs
//   d_ack/d_rdata                   : data requester response
//   err                             : out-of-range flag, pulses with the ack
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata : memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_r;
  grant_e            grant_r;
  logic              we_r;
  logic              oor_r;
  grant_e            last_grant_s;
  grant_e            pick_grant_s;
  logic              pick_valid_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;
  logic              sel_oor_s;
  logic [DATA_W-1:0] rsp_data_s;

  arb_pick u_arb_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant_s),
    .grant      (pick_grant_s),
    .valid      (pick_valid_s)
  );

`ifdef MEM_ARB_RR_EN
  grant_e last_grant_r;

  // History for round-robin: records the winner of every accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GNT_FETCH;
    end else if (state_r == IDLE && pick_valid_s) begin
      last_grant_r <= pick_grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = GNT_FETCH;
`endif

  // Request mux: fetch is always a read with no write data.
  always_comb begin
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    sel_we_s    = 1'b0;
    if (pick_grant_s == GNT_DATA) begin
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
      sel_we_s    = d_we;
    end else begin
      sel_addr_s  = if_addr;
      sel_wdata_s = {DATA_W{1'b0}};
      sel_we_s    = 1'b0;
    end
    sel_oor_s = (sel_addr_s >= ADDR_W'(DEPTH));
  end

  // Response data: only an in-range read returns memory contents.
  always_comb begin
    if (we_r || oor_r) begin
      rsp_data_s = {DATA_W{1'b0}};
    end else begin
      rsp_data_s = mem_rdata;
    end
  end

  // Sequencer: latches the winner in IDLE, drives the memory in ACCESS,
  // answers in RESP. Memory-port outputs are loaded on IDLE->ACCESS so they
  // are valid for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      grant_r   <= GNT_FETCH;
      we_r      <= 1'b0;
      oor_r     <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= {DATA_W{1'b0}};
      d_ack     <= 1'b0;
      d_rdata   <= {DATA_W{1'b0}};
      err       <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if_ack   <= 1'b0;
          if_rdata <= {DATA_W{1'b0}};
          d_ack    <= 1'b0;
          d_rdata  <= {DATA_W{1'b0}};
          err      <= 1'b0;
          if (pick_valid_s) begin
            grant_r   <= pick_grant_s;
            we_r      <= sel_we_s;
            oor_r     <= sel_oor_s;
            mem_addr  <= sel_oor_s ? {ADDR_W{1'b0}} : sel_addr_s;
            mem_wdata <= (sel_we_s && !sel_oor_s) ? sel_wdata_s : {DATA_W{1'b0}};
            mem_read  <= !sel_we_s && !sel_oor_s;
            mem_write <= sel_we_s && !sel_oor_s;
            state_r   <= ACCESS;
          end else begin
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_r   <= IDLE;
          end
        end
        ACCESS: begin
          mem_addr  <= {ADDR_W{1'b0}};
          mem_wdata <= {DATA_W{1'b0}};
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if_ack    <= (grant_r == GNT_FETCH);
          d_ack     <= (grant_r == GNT_DATA);
          if_rdata  <= (grant_r == GNT_FETCH) ? rsp_data_s : {DATA_W{1'b0}};
          d_rdata   <= (grant_r == GNT_DATA) ? rsp_data_s : {DATA_W{1'b0}};
          err       <= oor_r;
          state_r   <= RESP;
        end
        RESP: begin
          if_ack   <= 1'b0;
          if_rdata <= {DATA_W{1'b0}};
          d_ack    <= 1'b0;
          d_rdata  <= {DATA_W{1'b0}};
          err      <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          if_ack    <= 1'b0;
          if_rdata  <= {DATA_W{1'b0}};
          d_ack     <= 1'b0;
          d_rdata   <= {DATA_W{1'b0}};
          err       <= 1'b0;
          mem_addr  <= {ADDR_W{1'b0}};
          mem_wdata <= {DATA_W{1'b0}};
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
